control_pipe: RTL and testbench

- Parametrised successor to the single-cycle main decoder.
- Decodes instruction[6:0] into the control bundle, then carries the bundle, a valid bit and rd through NUM_STAGES pipeline registers (stage 0 = ID/EX ... last = MEM/WB).
- Adds global stall, EX-entry flush, internal load-use hazard detection, optional U-type decode, and illegal-opcode flagging.
- Sits between the IF/ID register and the datapath stage registers.

---
 rtl/control_pipe.sv | 140 ++++++++++++++
 tb/tb_control_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Main-decoder control pipeline: decodes opcode into a 12-bit control bundle and carries it with rd/valid through NUM_STAGES registers.
// Latency: id_ctrl/illegal/load_use_stall are combinational; the bundle reaches stage k at the edge ending cycle n+k.
// Backpressure: stall freezes every stage; load_use_stall makes fetch hold while one bubble enters stage 0.
module control_pipe #(
  parameter int NUM_STAGES = 3,
  parameter bit EN_UTYPE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic [6:0]              opcode,
  input  logic [4:0]              rd,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic                    stall,
  input  logic                    flush,
  output logic [11:0]             id_ctrl,
  output logic [12*NUM_STAGES-1:0] stage_ctrl,
  output logic [5*NUM_STAGES-1:0] stage_rd,
  output logic [NUM_STAGES-1:0]   stage_valid,
  output logic                    load_use_stall,
  output logic                    illegal,
  output logic                    illegal_seen
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Bundle bit positions: u_sel[11:10] jump[9:8] branch[7] mem_read[6]
  // mem_to_reg[5] alu_op[4:3] mem_write[2] alu_src[1] reg_write[0]
  localparam int MEM_READ_BIT = 6;

  logic [11:0] dec_ctrl;
  logic        legal;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        bubble;
  logic        rd0_hit;

  logic [11:0]           ctrl_q [NUM_STAGES];
  logic [4:0]            rd_q   [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q;
  logic                  seen_q;

  // Opcode decode into the raw bundle, legality and operand usage.
  always_comb begin
    dec_ctrl = '0;
    legal    = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R:     begin dec_ctrl = 12'h011; legal = 1'b1; uses_rs2 = 1'b1; end
      OP_I:     begin dec_ctrl = 12'h01B; legal = 1'b1; end
      OP_LOAD:  begin dec_ctrl = 12'h063; legal = 1'b1; end
      OP_STORE: begin dec_ctrl = 12'h006; legal = 1'b1; uses_rs2 = 1'b1; end
      OP_BR:    begin dec_ctrl = 12'h188; legal = 1'b1; uses_rs2 = 1'b1; end
      OP_JAL:   begin dec_ctrl = 12'h21B; legal = 1'b1; uses_rs1 = 1'b0; end
      OP_JALR:  begin dec_ctrl = 12'h31B; legal = 1'b1; end
      // U-type never reads rs1, even when disabled and flagged illegal.
      OP_LUI: begin
        uses_rs1 = 1'b0;
        if (EN_UTYPE) begin
          dec_ctrl = 12'h403;
          legal    = 1'b1;
        end
      end
      OP_AUIPC: begin
        uses_rs1 = 1'b0;
        if (EN_UTYPE) begin
          dec_ctrl = 12'h803;
          legal    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A write to x0 is architecturally discarded, so drop reg_write here.
  assign id_ctrl = {dec_ctrl[11:1], dec_ctrl[0] & (rd != 5'd0)};

  assign illegal = in_valid & ~legal;

  // Only stage 0 can hold a load whose result is not yet forwardable.
  assign rd0_hit = ((rd_q[0] == rs1) & uses_rs1) | ((rd_q[0] == rs2) & uses_rs2);
  assign load_use_stall = in_valid & valid_q[0] & ctrl_q[0][MEM_READ_BIT] &
                          (rd_q[0] != 5'd0) & rd0_hit;

  assign bubble = flush | load_use_stall | ~in_valid | illegal;

  // Stage registers: stall holds everything, otherwise shift and refill stage 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        ctrl_q[k] <= '0;
        rd_q[k]   <= '0;
      end
      valid_q <= '0;
    end else if (!stall) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        ctrl_q[k]  <= ctrl_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
      if (bubble) begin
        ctrl_q[0]  <= '0;
        rd_q[0]    <= '0;
        valid_q[0] <= 1'b0;
      end else begin
        ctrl_q[0]  <= id_ctrl;
        rd_q[0]    <= rd;
        valid_q[0] <= 1'b1;
      end
    end
  end

  // Sticky illegal flag; an illegal opcode seen during a stall is not yet consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seen_q <= 1'b0;
    end else if (illegal && !stall) begin
      seen_q <= 1'b1;
    end
  end

  assign illegal_seen = seen_q;
  assign stage_valid  = valid_q;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_pack
    assign stage_ctrl[12*g +: 12] = ctrl_q[g];
    assign stage_rd[5*g +: 5]     = rd_q[g];
  end

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: a 3-stage U-type-enabled instance and a 1-stage U-type-disabled instance share stimulus.
// Directed steps for the key behaviours, then a randomized run checked against an abstract stage-list model.
// Outputs are sampled on the falling edge; combinational outputs 1 time unit after inputs change.
module tb_control_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, in_valid, stall, flush;
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;

  logic [11:0] a_id_ctrl, b_id_ctrl;
  logic [35:0] a_stage_ctrl;
  logic [11:0] b_stage_ctrl;
  logic [14:0] a_stage_rd;
  logic [4:0]  b_stage_rd;
  logic [2:0]  a_stage_valid;
  logic [0:0]  b_stage_valid;
  logic        a_lus, b_lus, a_illegal, b_illegal, a_seen, b_seen;

  control_pipe #(.NUM_STAGES(3), .EN_UTYPE(1'b1)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .stall(stall), .flush(flush), .id_ctrl(a_id_ctrl),
    .stage_ctrl(a_stage_ctrl), .stage_rd(a_stage_rd), .stage_valid(a_stage_valid),
    .load_use_stall(a_lus), .illegal(a_illegal), .illegal_seen(a_seen));

  control_pipe #(.NUM_STAGES(1), .EN_UTYPE(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .stall(stall), .flush(flush), .id_ctrl(b_id_ctrl),
    .stage_ctrl(b_stage_ctrl), .stage_rd(b_stage_rd), .stage_valid(b_stage_valid),
    .load_use_stall(b_lus), .illegal(b_illegal), .illegal_seen(b_seen));

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: model 0 = 3 stages with U-type, model 1 = 1 stage without.
  logic [11:0] m_ctrl [2][3];
  logic [4:0]  m_rd   [2][3];
  logic        m_v    [2][3];
  logic        m_seen [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_asserts++;
    assert (got === want) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int depth(input int m);
    return (m == 0) ? 3 : 1;
  endfunction

  // Control bundle straight from the decode table.
  function automatic logic [11:0] table_ctrl(input logic [6:0] op, input logic en_u);
    case (op)
      R:     return 12'h011;
      I:     return 12'h01B;
      LD:    return 12'h063;
      ST:    return 12'h006;
      BR:    return 12'h188;
      JAL:   return 12'h21B;
      JALR:  return 12'h31B;
      LUI:   return en_u ? 12'h403 : 12'h000;
      AUIPC: return en_u ? 12'h803 : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic in_table(input logic [6:0] op, input logic en_u);
    if (op == LUI || op == AUIPC) return en_u;
    return (op == R || op == I || op == LD || op == ST || op == BR || op == JAL || op == JALR);
  endfunction

  task automatic model_comb(input int m, output logic [11:0] c, output logic lus, output logic ill);
    logic u1, u2, hit;
    c = table_ctrl(opcode, m == 0);
    if (rd == 5'd0) c[0] = 1'b0;
    u1  = !(opcode == JAL || opcode == LUI || opcode == AUIPC);
    u2  = (opcode == R || opcode == ST || opcode == BR);
    hit = (m_rd[m][0] == rs1 && u1) || (m_rd[m][0] == rs2 && u2);
    lus = in_valid && m_v[m][0] && m_ctrl[m][0][6] && m_rd[m][0] != 5'd0 && hit;
    ill = in_valid && !in_table(opcode, m == 0);
  endtask

  task automatic model_edge(input int m);
    logic [11:0] c;
    logic lus, ill;
    model_comb(m, c, lus, ill);
    if (!stall) begin
      for (int k = depth(m) - 1; k >= 1; k--) begin
        m_ctrl[m][k] = m_ctrl[m][k-1];
        m_rd[m][k]   = m_rd[m][k-1];
        m_v[m][k]    = m_v[m][k-1];
      end
      if (flush || lus || !in_valid || ill) begin
        m_ctrl[m][0] = '0; m_rd[m][0] = '0; m_v[m][0] = 1'b0;
      end else begin
        m_ctrl[m][0] = c; m_rd[m][0] = rd; m_v[m][0] = 1'b1;
      end
      if (ill) m_seen[m] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) begin
        m_ctrl[m][k] = '0; m_rd[m][k] = '0; m_v[m][k] = 1'b0;
      end
      m_seen[m] = 1'b0;
    end
  endtask

  task automatic check_comb();
    logic [11:0] c;
    logic lus, ill;
    model_comb(0, c, lus, ill);
    chk("a_id_ctrl", 32'(a_id_ctrl), 32'(c));
    chk("a_load_use", 32'(a_lus), 32'(lus));
    chk("a_illegal", 32'(a_illegal), 32'(ill));
    model_comb(1, c, lus, ill);
    chk("b_id_ctrl", 32'(b_id_ctrl), 32'(c));
    chk("b_load_use", 32'(b_lus), 32'(lus));
    chk("b_illegal", 32'(b_illegal), 32'(ill));
  endtask

  task automatic check_regs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("a_ctrl%0d", k), 32'(a_stage_ctrl[12*k +: 12]), 32'(m_ctrl[0][k]));
      chk($sformatf("a_rd%0d", k), 32'(a_stage_rd[5*k +: 5]), 32'(m_rd[0][k]));
      chk($sformatf("a_valid%0d", k), 32'(a_stage_valid[k]), 32'(m_v[0][k]));
    end
    chk("a_seen", 32'(a_seen), 32'(m_seen[0]));
    chk("b_ctrl0", 32'(b_stage_ctrl), 32'(m_ctrl[1][0]));
    chk("b_rd0", 32'(b_stage_rd), 32'(m_rd[1][0]));
    chk("b_valid0", 32'(b_stage_valid[0]), 32'(m_v[1][0]));
    chk("b_seen", 32'(b_seen), 32'(m_seen[1]));
  endtask

  // Called on a falling edge: apply inputs and check the combinational outputs.
  task automatic drive(input logic iv, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic st, input logic fl);
    in_valid = iv; opcode = op; rd = d; rs1 = s1; rs2 = s2; stall = st; flush = fl;
    #1;
    check_comb();
  endtask

  // Advance one clock: update the model at the rising edge, check registers at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_regs();
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC, 7'b1111111};
    rstn = 1'b0; in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    stall = 1'b0; flush = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    check_regs();
    check_comb();
    chk("rst_valid", 32'(a_stage_valid), 32'd0);
    rstn = 1'b1;

    // R-type through the pipe
    drive(1'b1, R, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0);
    tick();
    chk("r_stage0", 32'(a_stage_ctrl[11:0]), 32'h011);
    drive(1'b1, R, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    drive(1'b1, R, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    chk("r_stage2", 32'(a_stage_ctrl[35:24]), 32'h011);
    chk("r_full", 32'(a_stage_valid), 32'b111);

    // Load-use on rs2 inserts exactly one bubble
    drive(1'b1, LD, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    drive(1'b1, R, 5'd9, 5'd1, 5'd7, 1'b0, 1'b0);
    chk("lu_stall", 32'(a_lus), 32'd1);
    tick();
    chk("lu_bubble_v", 32'(a_stage_valid[0]), 32'd0);
    chk("lu_bubble_c", 32'(a_stage_ctrl[11:0]), 32'h000);
    drive(1'b1, R, 5'd9, 5'd1, 5'd7, 1'b0, 1'b0);
    chk("lu_release", 32'(a_lus), 32'd0);
    tick();
    chk("lu_add_c", 32'(a_stage_ctrl[11:0]), 32'h011);
    chk("lu_add_rd", 32'(a_stage_rd[4:0]), 32'd9);

    // I-type ignores rs2, so no hazard
    drive(1'b1, LD, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    drive(1'b1, I, 5'd3, 5'd1, 5'd7, 1'b0, 1'b0);
    chk("lu_itype", 32'(a_lus), 32'd0);
    tick();

    // Stall beats flush; flush after stall drops kills stage 0
    drive(1'b1, R, 5'd4, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    drive(1'b1, R, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1); tick();
    drive(1'b1, R, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1); tick();
    chk("stall_hold", 32'(a_stage_valid), 32'b111);
    drive(1'b1, R, 5'd4, 5'd1, 5'd2, 1'b0, 1'b1); tick();
    chk("flush_bubble", 32'(a_stage_valid), 32'b110);

    // Write to x0 clears reg_write
    drive(1'b1, I, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    chk("x0_ctrl", 32'(a_stage_ctrl[11:0]), 32'h01A);

    // Undecodable opcode
    drive(1'b1, 7'b1111111, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0);
    chk("ill_flag", 32'(a_illegal), 32'd1);
    tick();
    chk("ill_bubble", 32'(a_stage_valid[0]), 32'd0);
    chk("ill_seen", 32'(a_seen), 32'd1);

    // LUI legal only where U-type is enabled
    drive(1'b1, LUI, 5'd4, 5'd1, 5'd2, 1'b0, 1'b0);
    chk("lui_id", 32'(a_id_ctrl), 32'h403);
    chk("lui_b_ill", 32'(b_illegal), 32'd1);
    tick();
    chk("lui_a_s0", 32'(a_stage_ctrl[11:0]), 32'h403);
    chk("lui_b_s0", 32'(b_stage_valid[0]), 32'd0);

    // Asynchronous reset with a full pipe
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, R, 5'd2, 5'd1, 5'd3, 1'b0, 1'b0); tick();
    end
    chk("pre_rst_full", 32'(a_stage_valid), 32'b111);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(a_stage_valid), 32'd0);
    chk("arst_seen", 32'(a_seen), 32'd0);
    check_regs();
    @(negedge clk);
    rstn = 1'b1;
    check_regs();

    // Randomized run
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 9) != 0), ops[$urandom_range(0, 9)],
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      if (opcode == 7'b1111111 && $urandom_range(0, 1) == 0) opcode = 7'($urandom);
      #1;
      check_comb();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
